// File: rtl/memory_dump_reader.sv
// Memory dump reader: walks the data memory from address 0 to MEMORY_DEPTH-1,
// reads each byte through the debug read port and offers it to a transmitter
// over a valid/ready handshake. One READ, one WAIT (memory latency) and at least
// one SEND cycle per byte; a one-cycle done pulse closes the dump.
module memory_dump_reader #(
  parameter int unsigned MEMORY_WIDTH = 8,
  parameter int unsigned MEMORY_DEPTH = 128,
  parameter int unsigned NB_ADDR      = 7
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  output logic                    o_mem_enable,
  output logic                    o_mem_read_enable,
  output logic [NB_ADDR-1:0]      o_mem_read_address,
  input  logic [MEMORY_WIDTH-1:0] i_mem_byte_data,
  output logic [MEMORY_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StDone
  } state_e;

  localparam logic [NB_ADDR-1:0] LastAddr = NB_ADDR'(MEMORY_DEPTH - 1);
  localparam logic [NB_ADDR-1:0] AddrOne  = NB_ADDR'(1);

  state_e                  state_q;
  logic [NB_ADDR-1:0]      addr_q;
  logic [MEMORY_WIDTH-1:0] tx_data_q;
  logic                    mem_en_q;
  logic                    tx_valid_q;
  logic                    busy_q;
  logic                    done_q;

  // FSM with registered outputs: each output flop is set on the edge that enters
  // the state in which it must be high, so outputs line up with the state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      tx_data_q  <= '0;
      mem_en_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      mem_en_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_start) begin
            addr_q   <= '0;
            state_q  <= StRead;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StRead: begin
          // Memory registers the byte on this edge; it is visible during WAIT.
          state_q <= StWait;
        end
        StWait: begin
          tx_data_q  <= i_mem_byte_data;
          tx_valid_q <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          // tx_data_q is untouched here, so the byte holds under backpressure.
          if (i_tx_ready) begin
            tx_valid_q <= 1'b0;
            if (addr_q == LastAddr) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              addr_q   <= addr_q + AddrOne;
              state_q  <= StRead;
              mem_en_q <= 1'b1;
            end
          end
        end
        StDone: begin
          addr_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q    <= StIdle;
          addr_q     <= '0;
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Both memory enables are asserted together for the single READ cycle.
  always_comb begin
    o_mem_enable       = mem_en_q;
    o_mem_read_enable  = mem_en_q;
    o_mem_read_address = addr_q;
    o_tx_data          = tx_data_q;
    o_tx_valid         = tx_valid_q;
    o_busy             = busy_q;
    o_done             = done_q;
  end

endmodule

// File: tb/tb_memory_dump_reader.sv
// Testbench for memory_dump_reader: a per-cycle vector table for the start of a
// dump, then scoreboarded full dumps with backpressure, ignored start, reset
// abort, and a small MEMORY_DEPTH=4 instance.
module tb_memory_dump_reader;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // Main instance: 128 x 8
  logic       start, ready;
  logic       en, ren, valid, busy, done;
  logic [6:0] addr;
  logic [7:0] rdata, data;

  memory_dump_reader #(
    .MEMORY_WIDTH(8),
    .MEMORY_DEPTH(128),
    .NB_ADDR     (7)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_start           (start),
    .o_mem_enable      (en),
    .o_mem_read_enable (ren),
    .o_mem_read_address(addr),
    .i_mem_byte_data   (rdata),
    .o_tx_data         (data),
    .o_tx_valid        (valid),
    .i_tx_ready        (ready),
    .o_busy            (busy),
    .o_done            (done)
  );

  // Registered memory model, contents A ^ 8'h5A
  always_ff @(posedge clk) if (ren) rdata <= {1'b0, addr} ^ 8'h5A;

  // Small instance: 4 x 8
  logic       s_start, s_ready;
  logic       s_en, s_ren, s_valid, s_busy, s_done;
  logic [1:0] s_addr;
  logic [7:0] s_rdata, s_data;

  memory_dump_reader #(
    .MEMORY_WIDTH(8),
    .MEMORY_DEPTH(4),
    .NB_ADDR     (2)
  ) dut_s (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_start           (s_start),
    .o_mem_enable      (s_en),
    .o_mem_read_enable (s_ren),
    .o_mem_read_address(s_addr),
    .i_mem_byte_data   (s_rdata),
    .o_tx_data         (s_data),
    .o_tx_valid        (s_valid),
    .i_tx_ready        (s_ready),
    .o_busy            (s_busy),
    .o_done            (s_done)
  );

  always_ff @(posedge clk) if (s_ren) s_rdata <= {6'b0, s_addr} ^ 8'h5A;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_main();
    return {12'b0, busy, en, ren, valid, done, addr, data};
  endfunction

  typedef struct {
    logic       start;
    logic       ready;
    logic       busy;
    logic       en;
    logic       valid;
    logic       done;
    logic [6:0] addr;
    logic [7:0] data;
  } vec_t;

  // Full dump on the main instance, with optional backpressure, start pulse and abort.
  task automatic run_dump(input int bp_addr, input int pulse_addr, input int abort_addr,
                          input int exp_done);
    int  idx;
    int  rd;
    int  n;
    bit  bp_done;
    bit  finished;
    idx = 0; rd = 0; bp_done = 0; finished = 0;
    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    n = 0;
    while (n < 700 && !finished) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (ren) begin
        check("read_addr", 32'(addr), 32'(rd));
        check("mem_enable", 32'(en), 32'd1);
        rd++;
      end
      if (valid) begin
        check("tx_data", 32'(data), 32'((idx ^ 8'h5A) & 8'hFF));
        if (idx == abort_addr) begin
          #2 rst = 1'b1;
          #1 check("abort_outputs", pack_main(), 32'd0);
          @(negedge clk);
          rst = 1'b0;
          return;
        end
        if (idx == bp_addr && !bp_done) begin
          bp_done = 1;
          ready = 1'b0;
          for (int j = 0; j < 10; j++) begin
            check("bp_valid_data_noread", {22'b0, valid, ren, data}, {22'b0, 2'b10,
                  8'(idx ^ 8'h5A)});
            @(negedge clk);
            n++;
          end
          ready = 1'b1;
          check("bp_hold_end", {23'b0, valid, data}, {23'b0, 1'b1, 8'(idx ^ 8'h5A)});
        end
        if (idx == pulse_addr) start = 1'b1;
        if (ready) idx++;
      end
      if (done) begin
        finished = 1;
        check("done_cycle", 32'(n), 32'(exp_done));
        check("bytes_sent", 32'(idx), 32'd128);
        check("reads_issued", 32'(rd), 32'd128);
      end
    end
    if (!finished) check("dump_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vec_t vecs[9];
    int   idx, rd, n;
    bit   finished;

    //        start ready busy en valid done addr   data
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00}; // IDLE
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 8'h00}; // READ 0
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00}; // WAIT
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, 8'h5A}; // SEND 0
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd1, 8'h5A}; // READ 1
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd1, 8'h5A}; // WAIT
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 8'h5B}; // SEND 1, stalled
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'd1, 8'h5B}; // SEND 1, start ignored
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 7'd2, 8'h5B}; // READ 2

    rst = 1'b1; start = 1'b0; ready = 1'b1; s_start = 1'b0; s_ready = 1'b1;
    #12;
    check("reset_outputs", pack_main(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), pack_main(),
            {12'b0, vecs[i].busy, vecs[i].en, vecs[i].en, vecs[i].valid, vecs[i].done,
             vecs[i].addr, vecs[i].data});
      start = vecs[i].start;
      ready = vecs[i].ready;
    end
    start = 1'b0;
    ready = 1'b1;

    // Asynchronous reset mid-dump, away from any edge
    #2 rst = 1'b1;
    #1 check("async_reset_mid_dump", pack_main(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_dump(-1, -1, -1, 385);
    run_dump(5, 20, -1, 395);
    run_dump(-1, -1, -1, 385);
    run_dump(-1, -1, 40, 0);
    run_dump(-1, -1, -1, 385);

    // Depth-4 instance
    idx = 0; rd = 0; finished = 0;
    @(negedge clk);
    s_start = 1'b1;
    n = 0;
    while (n < 40 && !finished) begin
      @(negedge clk);
      n++;
      s_start = 1'b0;
      if (s_ren) begin
        check("s_read_addr", 32'(s_addr), 32'(rd));
        rd++;
      end
      if (s_valid) begin
        check("s_tx_data", 32'(s_data), 32'((idx ^ 8'h5A) & 8'hFF));
        idx++;
      end
      if (s_done) begin
        finished = 1;
        check("s_done_cycle", 32'(n), 32'd13);
        check("s_bytes_sent", 32'(idx), 32'd4);
        check("s_reads_issued", 32'(rd), 32'd4);
      end
    end
    if (!finished) check("s_dump_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("s_idle_after_done", {28'b0, s_busy, s_ren, s_addr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_dump_reader.md
MEMORY_DUMP_READER -- requirements
Module: memory_dump_reader

Interface
REQ-001 The module SHALL have parameter MEMORY_WIDTH, default 8, width of one data-memory byte entry.
REQ-002 The module SHALL have parameter MEMORY_DEPTH, default 128, number of data-memory entries dumped.
REQ-003 The module SHALL have parameter NB_ADDR, default 7, data-memory address width.
REQ-004 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The module SHALL have port i_clock  input  1  sole clock, all state updates on rising edge.
REQ-006 The module SHALL have port i_reset  input  1  asynchronous active-high reset.
REQ-007 The module SHALL have port i_start  input  1  request a full dump; sampled only in IDLE.
REQ-008 The module SHALL have port o_mem_enable  output  1  drives data-memory enable during a read.
REQ-009 The module SHALL have port o_mem_read_enable  output  1  drives data-memory debug read enable.
REQ-010 The module SHALL have port o_mem_read_address  output  NB_ADDR  drives data-memory debug read address.
REQ-011 The module SHALL have port i_mem_byte_data  input  MEMORY_WIDTH  registered debug byte from data memory.
REQ-012 The module SHALL have port o_tx_data  output  MEMORY_WIDTH  byte offered to the transmitter.
REQ-013 The module SHALL have port o_tx_valid  output  1  o_tx_data valid.
REQ-014 The module SHALL have port i_tx_ready  input  1  transmitter accepts o_tx_data this cycle.
REQ-015 The module SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-016 The module SHALL have port o_done  output  1  one-cycle pulse after the last byte is accepted.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WAIT, SEND, DONE.
REQ-018 IDLE: i_start high at an edge SHALL load address 0 and move to READ; otherwise stay.
REQ-019 READ: o_mem_enable and o_mem_read_enable SHALL be 1 for exactly one cycle with o_mem_read_address = current address; next state WAIT.
REQ-020 WAIT: i_mem_byte_data (memory's 1-cycle read latency) SHALL be captured into the o_tx_data register at the edge ending WAIT; next state SEND.
REQ-021 SEND: o_tx_valid SHALL be 1; o_tx_data SHALL stay constant while o_tx_valid=1 and i_tx_ready=0.
REQ-022 SEND handshake: on an edge with o_tx_valid=1 and i_tx_ready=1, if address = MEMORY_DEPTH-1 next state SHALL be DONE, else address SHALL increment by 1 and next state SHALL be READ.
REQ-023 DONE: o_done SHALL be 1 for one cycle; next state IDLE; address SHALL return to 0.
REQ-024 o_mem_enable and o_mem_read_enable SHALL be 0 in all states except READ.
REQ-025 o_tx_valid SHALL be 0 in all states except SEND.
REQ-026 i_start SHALL be ignored in READ, WAIT, SEND, DONE (no restart, no queueing).
REQ-027 Bytes SHALL be emitted in ascending address order 0..MEMORY_DEPTH-1, each exactly once per dump.
REQ-028 Address counter SHALL be NB_ADDR bits and SHALL never exceed MEMORY_DEPTH-1 (no wrap-around).
REQ-029 Timing with i_tx_ready held 1: i_start at edge k -> READ cycle k+1, o_tx_valid cycle k+3, 3 cycles per byte, o_done cycle k+3*MEMORY_DEPTH+1.

Reset
REQ-030 i_reset high SHALL immediately force IDLE, address 0, o_tx_data 0, and all other outputs 0, regardless of state.
REQ-031 After i_reset deasserts, a new i_start SHALL dump from address 0; no partial dump state survives.

Verification
REQ-032 Reset: assert i_reset in any state -> all outputs 0 asynchronously, o_busy=0.
REQ-033 Full dump, ready tied 1, memory[A]=A^8'h5A: 128 handshakes with o_tx_data=A^8'h5A for A=0..127 in order, o_done at start edge+385, one read_enable per byte.
REQ-034 Backpressure: hold i_tx_ready=0 for 10 cycles on address 5 -> o_tx_valid=1 and o_tx_data=8'h5F stable all 10 cycles, no read_enable issued, dump resumes at address 6.
REQ-035 i_start pulsed during SEND of address 20 -> ignored, dump continues to 127; i_start after o_done -> new dump from address 0.
REQ-036 i_reset mid-SEND at address 40 -> IDLE, outputs 0; next i_start -> first byte from address 0.
REQ-037 MEMORY_DEPTH=4, NB_ADDR=2: exactly 4 bytes (addresses 0..3) then o_done, address never wraps.
